// File: rtl/edge_pkg.sv
// edge_pkg: shared types and constants for the edge_frame_ctrl slice.
//   pixel_t      24-bit {R,G,B}
//   column_t     one 3-pixel window column, [2]=top, [1]=middle, [0]=bottom
//   window_t     3x3 window, [8]=top-left ... [0]=bottom-right, row-major
//   ctrl_state_t frame sequencer states
//   result_t     emitted pixel with its centre coordinates
package edge_pkg;

    typedef logic [23:0] pixel_t;
    typedef pixel_t [2:0] column_t;
    typedef pixel_t [8:0] window_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} ctrl_state_t;

    typedef struct packed {
        pixel_t      pixel;
        logic [15:0] row;
        logic [15:0] col;
    } result_t;

    localparam pixel_t BLACK_PIXEL = 24'h000000;

    // Assemble a row-major window (top row first) from left/middle/right columns.
    function automatic window_t build_window(input column_t l, input column_t m,
                                             input column_t r);
        return {l[2], m[2], r[2], l[1], m[1], r[1], l[0], m[0], r[0]};
    endfunction

endpackage

// File: rtl/edge_line_buffer.sv
// edge_line_buffer: two MAX_W-deep line stores holding the previous two
// image rows. The column at addr_i is read before it is overwritten, so the
// returned column is {row r-2, row r-1, incoming pixel of row r}.
//   clk       in   clock
//   wr_en_i   in   accepted pixel: shift this column down one row
//   addr_i    in   column address
//   pixel_i   in   incoming pixel
//   column_o  out  {top, middle, bottom} pixels of the current column
module edge_line_buffer
    import edge_pkg::*;
#(
    parameter int unsigned MAX_W = 1024
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(MAX_W)-1:0] addr_i,
    input  pixel_t                   pixel_i,
    output column_t                  column_o
);

    pixel_t row1_q [MAX_W];  // row r-1
    pixel_t row2_q [MAX_W];  // row r-2

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            row2_q[addr_i] <= row1_q[addr_i];
            row1_q[addr_i] <= pixel_i;
        end
    end

    assign column_o = {row2_q[addr_i], row1_q[addr_i], pixel_i};

endmodule

// File: rtl/edge_frame_ctrl.sv
// edge_frame_ctrl: sequences a raster-order 24bpp image through an external
// intensity/edgedetect pipeline. Builds 3x3 windows for interior pixels,
// tracks PIPE_LAT latency, captures isEdge and emits black (edge) or the
// original centre pixel with its coordinates through a skid FIFO.
//   start/cfg_width/cfg_height  frame start and geometry (err on bad geometry)
//   in_valid/in_ready/in_pixel  pixel input handshake
//   win_valid/win_data          window to the intensity stage
//   edge_in                     isEdge, PIPE_LAT cycles after win_valid
//   out_valid/out_ready/out_*   result handshake, pixel, centre row/col
//   busy/done/err               status
// Optional: define EDGE_CTRL_STATS_EN to add edge_count (edges captured in
// the current/last frame).
module edge_frame_ctrl
    import edge_pkg::*;
#(
    parameter int unsigned MAX_W      = 1024,
    parameter int unsigned PIPE_LAT   = 3,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [15:0]  cfg_width,
    input  logic [15:0]  cfg_height,
    input  logic         in_valid,
    input  logic [23:0]  in_pixel,
    output logic         in_ready,
    output logic         win_valid,
    output logic [215:0] win_data,
    input  logic         edge_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [23:0]  out_pixel,
    output logic [15:0]  out_row,
    output logic [15:0]  out_col,
    output logic         busy,
    output logic         done,
    output logic         err
`ifdef EDGE_CTRL_STATS_EN
    ,
    output logic [31:0]  edge_count
`endif
);

    localparam int unsigned AW = $clog2(MAX_W);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    ctrl_state_t   state_q, state_d;
    logic [15:0]   w_q, w_d, h_q, h_d, row_q, row_d, col_q, col_d;
    logic          done_q, done_d, err_q, err_d, start_ok;

    column_t       lb_col, c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
    logic          win_valid_q;
    window_t       win_data_q;
    result_t       win_res_q;
    logic          dl_valid_q [PIPE_LAT];
    result_t       dl_res_q   [PIPE_LAT];

    result_t       fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] fifo_cnt_q, inflight_q;
    logic [CW:0]   occupancy;

    logic          cfg_ok, accept, issue, capture, pop, last_col, last_row;
    result_t       cap_res;

    assign cfg_ok    = (cfg_width >= 16'd3) && (cfg_width <= 16'(MAX_W)) &&
                       (cfg_height >= 16'd3);
    assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign in_ready  = (state_q == RUN) && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign last_col  = (col_q == w_q - 16'd1);
    assign last_row  = (row_q == h_q - 16'd1);
    assign issue     = accept && (row_q >= 16'd2) && (col_q >= 16'd2);
    assign capture   = dl_valid_q[PIPE_LAT-1];
    assign pop       = out_valid && out_ready;

    always_comb begin
        cap_res = dl_res_q[PIPE_LAT-1];
        if (edge_in) cap_res.pixel = BLACK_PIXEL;
    end

    // ---------------- frame sequencer ----------------
    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        h_d      = h_q;
        row_d    = row_q;
        col_d    = col_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        start_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        w_d      = cfg_width;
                        h_d      = cfg_height;
                        row_d    = '0;
                        col_d    = '0;
                        start_ok = 1'b1;
                        state_d  = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                        if (last_row) state_d = DRAIN;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) && (fifo_cnt_q == '0)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // ---------------- window assembly ----------------
    edge_line_buffer #(.MAX_W(MAX_W)) u_line_buffer (
        .clk      (clk),
        .wr_en_i  (accept),
        .addr_i   (col_q[AW-1:0]),
        .pixel_i  (in_pixel),
        .column_o (lb_col)
    );

    // Older columns are cleared at each row start so no column of the
    // previous row can leak into a window.
    always_comb begin
        c0_d = c0_q;
        c1_d = c1_q;
        c2_d = c2_q;
        if (accept) begin
            c0_d = (col_q == '0) ? '0 : c1_q;
            c1_d = (col_q == '0) ? '0 : c2_q;
            c2_d = lb_col;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            c0_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_res_q   <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                dl_valid_q[i] <= 1'b0;
                dl_res_q[i]   <= '0;
            end
        end else begin
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            win_valid_q <= issue;
            if (issue) begin
                win_data_q <= build_window(c0_d, c1_d, c2_d);
                win_res_q  <= '{pixel: c1_d[1], row: row_q - 16'd1, col: col_q - 16'd1};
            end
            dl_valid_q[0] <= win_valid_q;
            dl_res_q[0]   <= win_res_q;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
                dl_res_q[i]   <= dl_res_q[i-1];
            end
        end
    end

    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;

    // ---------------- inflight tracking and result FIFO ----------------
    // inflight counts a window from the accepting edge (one cycle ahead of
    // win_valid) so in_ready never admits a window the FIFO cannot hold.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            case ({issue, capture})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: inflight_q <= inflight_q;
            endcase
            case ({capture, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            if (capture) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (capture) fifo_q[wr_ptr_q] <= cap_res;
    end

    assign out_valid = (fifo_cnt_q != '0);
    assign out_pixel = out_valid ? fifo_q[rd_ptr_q].pixel : '0;
    assign out_row   = out_valid ? fifo_q[rd_ptr_q].row   : '0;
    assign out_col   = out_valid ? fifo_q[rd_ptr_q].col   : '0;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

`ifdef EDGE_CTRL_STATS_EN
    logic [31:0] edge_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                 edge_cnt_q <= '0;
        else if (start_ok)          edge_cnt_q <= '0;
        else if (capture && edge_in) edge_cnt_q <= edge_cnt_q + 32'd1;
    end

    assign edge_count = edge_cnt_q;
`endif

endmodule

// File: tb/tb_edge_frame_ctrl.sv
`timescale 1ns/1ps
module tb_edge_frame_ctrl;
    import edge_pkg::*;

    localparam int PIPE_LAT   = 3;
    localparam int FIFO_DEPTH = 8;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         start;
    logic [15:0]  cfg_width, cfg_height;
    logic         in_valid;
    logic [23:0]  in_pixel;
    logic         in_ready;
    logic         win_valid;
    logic [215:0] win_data;
    logic         edge_in;
    logic         out_valid, out_ready;
    logic [23:0]  out_pixel;
    logic [15:0]  out_row, out_col;
    logic         busy, done, err;
`ifdef EDGE_CTRL_STATS_EN
    logic [31:0]  edge_count;
`endif

    always #5 clk = ~clk;

    edge_frame_ctrl #(.MAX_W(1024), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .edge_in    (edge_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_row    (out_row),
        .out_col    (out_col),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef EDGE_CTRL_STATS_EN
        ,
        .edge_count (edge_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference edge detector: intensity=(R+G+B)/3, edge when spread > 90.
    function automatic int inten(input logic [23:0] p);
        return (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
    endfunction

    function automatic logic edge_of(input logic [215:0] w);
        int mx = 0;
        int mn = 255;
        for (int k = 0; k < 9; k++) begin
            int v;
            v = inten(w[k*24 +: 24]);
            if (v > mx) mx = v;
            if (v < mn) mn = v;
        end
        return (mx - mn) > 90;
    endfunction

    // External intensity+edgedetect stage: answer PIPE_LAT cycles after win_valid.
    logic [PIPE_LAT-1:0] e_pipe = '0;
    always @(posedge clk) e_pipe <= {e_pipe[PIPE_LAT-2:0], win_valid && edge_of(win_data)};
    assign edge_in = e_pipe[PIPE_LAT-1];

    // Image and scoreboard
    logic [23:0]  img [0:4095];
    int           cur_w;
    result_t      q_res[$];
    logic [215:0] q_win[$];

    function automatic logic [215:0] exp_window(input int r, input int c);
        logic [215:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[(8 - (dr*3 + dc))*24 +: 24] = img[(r - 2 + dr)*cur_w + (c - 2 + dc)];
        return w;
    endfunction

    task automatic fill_image(input int w, input int h, input int pat);
        logic [7:0] v;
        cur_w = w;
        for (int i = 0; i < w*h; i++) begin
            int r, c;
            r = i / w;
            c = i % w;
            case (pat)
                0: begin v = 8'(16 * i); img[i] = {v, v, v}; end
                1: img[i] = (c < (w + 1) / 2) ? 24'h000000 : 24'hFFFFFF;
                2: begin
                    v = 8'(r*20 + c*5);
                    img[i] = ((r*8 + c) % 7 == 3) ? 24'hFFFFFF : {v, v, v};
                end
                default: img[i] = 24'($urandom);
            endcase
        end
    endtask

    typedef struct {
        int w;
        int h;
        int pat;
        int rdy_mode;   // 0: out_ready always 1, 1: 1-in-4 plus input gaps
        int exp_n;
        bit exp_err;
        int exp_edges;  // -1: use model count
    } vec_t;

    vec_t vecs[8];

    task automatic run_frame(input vec_t v, input string tag);
        int idx, npix, n_out, cyc, viol, stall_viol, edges, outstanding;
        bit saw_done, prev_stall;
        logic [63:0] prev_out;
        idx = 0; n_out = 0; cyc = 0; viol = 0; stall_viol = 0; edges = 0;
        outstanding = 0; saw_done = 0; prev_stall = 0; prev_out = '0;
        npix = v.w * v.h;
        q_res.delete();
        q_win.delete();
        if (!v.exp_err) fill_image(v.w, v.h, v.pat);

        @(negedge clk);
        start = 1'b1;
        cfg_width = 16'(v.w);
        cfg_height = 16'(v.h);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err"}, 256'(err), 256'(v.exp_err));
        check({tag, "_busy"}, 256'(busy), 256'(!v.exp_err));
        if (v.exp_err) begin
            @(negedge clk);
            check({tag, "_err_pulse"}, 256'({err, busy}), 256'(0));
            return;
        end

        while (!saw_done && cyc < npix*8 + 200) begin
            if (v.rdy_mode == 1 && cyc == 10) begin
                start = 1'b1;
                cfg_width = 16'd2;
            end
            if (v.rdy_mode == 1 && cyc == 11) begin
                start = 1'b0;
                cfg_width = 16'(v.w);
                check({tag, "_start_busy"}, 256'({err, busy}), 256'(2'b01));
            end
            if (prev_stall && ({out_valid, out_pixel, out_row, out_col} !== {1'b1, prev_out[55:0]}))
                stall_viol++;
            if (win_valid) begin
                if (q_win.size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s_win: got extra window %0h want none", tag, win_data);
                end else begin
                    check({tag, "_win"}, 256'(win_data), 256'(q_win.pop_front()));
                end
            end
            if (done) saw_done = 1'b1;

            // input side
            in_valid = (idx < npix) && (v.rdy_mode == 0 || $urandom_range(0, 3) != 0);
            in_pixel = in_valid ? img[idx] : 24'h0;
            if (busy && idx < npix && (in_ready !== (outstanding < FIFO_DEPTH))) viol++;
            if (in_valid && in_ready) begin
                int r, c;
                r = idx / v.w;
                c = idx % v.w;
                if (r >= 2 && c >= 2) begin
                    logic [215:0] ew;
                    logic         e;
                    ew = exp_window(r, c);
                    e = edge_of(ew);
                    q_win.push_back(ew);
                    q_res.push_back('{pixel: e ? 24'h0 : img[idx - v.w - 1],
                                      row: 16'(r - 1), col: 16'(c - 1)});
                    if (e) edges++;
                    outstanding++;
                end
                idx++;
            end

            // output side
            out_ready = (v.rdy_mode == 0) || (cyc % 4 == 0);
            if (out_valid && out_ready) begin
                if (q_res.size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s_res: got extra result %0h want none", tag, {out_pixel, out_row, out_col});
                end else begin
                    check({tag, "_res"}, 256'({out_pixel, out_row, out_col}), 256'(q_res.pop_front()));
                end
                outstanding--;
                n_out++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out = 64'({out_pixel, out_row, out_col});
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_done_seen"}, 256'(saw_done), 256'(1));
        check({tag, "_count"}, 256'(n_out), 256'(v.exp_n));
        check({tag, "_pending"}, 256'(q_res.size() + q_win.size()), 256'(0));
        check({tag, "_inready_rule"}, 256'(viol), 256'(0));
        check({tag, "_stall_hold"}, 256'(stall_viol), 256'(0));
        check({tag, "_idle_after"}, 256'({busy, done}), 256'(0));
`ifdef EDGE_CTRL_STATS_EN
        check({tag, "_edge_count"}, 256'(edge_count), 256'(v.exp_edges >= 0 ? v.exp_edges : edges));
`endif
    endtask

    initial begin
        bit extra_done;
        int idx;
        vecs[0] = '{4,    4,  0, 0, 4,    1'b0, -1};
        vecs[1] = '{5,    5,  1, 0, 9,    1'b0,  6};
        vecs[2] = '{8,    8,  2, 1, 36,   1'b0, -1};
        vecs[3] = '{2,    10, 0, 0, 0,    1'b1, -1};
        vecs[4] = '{1025, 4,  0, 0, 0,    1'b1, -1};
        vecs[5] = '{6,    2,  0, 0, 0,    1'b1, -1};
        vecs[6] = '{1024, 3,  3, 0, 1022, 1'b0, -1};
        vecs[7] = '{3,    3,  2, 0, 1,    1'b0, -1};

        start = 1'b0; cfg_width = '0; cfg_height = '0;
        in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
        #1 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 256'({in_ready, win_valid, out_valid, busy, done, err}), 256'(0));
        check("rst_win", 256'(win_data), 256'(0));
        check("rst_out", 256'({out_pixel, out_row, out_col}), 256'(0));
`ifdef EDGE_CTRL_STATS_EN
        check("rst_edge_count", 256'(edge_count), 256'(0));
`endif
        n_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of a 10x10 frame with results parked in the FIFO.
        fill_image(10, 10, 2);
        @(negedge clk);
        start = 1'b1; cfg_width = 16'd10; cfg_height = 16'd10;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 60 && idx < 25; k++) begin
            in_valid = 1'b1;
            in_pixel = img[idx];
            if (in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_pre_fifo", 256'({out_valid, busy}), 256'(2'b11));
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_ctrl", 256'({in_ready, win_valid, out_valid, busy, done, err}), 256'(0));
        check("mid_rst_out", 256'({out_pixel, out_row, out_col}), 256'(0));
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        extra_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || out_valid) extra_done = 1'b1;
        end
        check("mid_no_done", 256'(extra_done), 256'(0));
        run_frame(vecs[7], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
